// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the fetch stage and the control unit:
// fetch FSM states, instruction field positions and base opcodes.
package rv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] RV_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    // Instruction field positions
    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_MSB = 6;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_MSB = 14;
    localparam int unsigned FUNCT7_LSB = 25;
    localparam int unsigned FUNCT7_MSB = 31;
    localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int unsigned FUNCT3_W   = FUNCT3_MSB - FUNCT3_LSB + 1;
    localparam int unsigned FUNCT7_W   = FUNCT7_MSB - FUNCT7_LSB + 1;

    // Base opcodes decoded by control_unit
    localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_FAULT
    } fetch_state_e;

    // Instruction fetches must be word aligned (no compressed support).
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: instruction-memory request/response channel
// plus the instruction/PC handoff to the control unit and register file.
interface fetch_unit_if;
    import rv_pkg::*;

    // Instruction memory side
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [XLEN-1:0]     imem_addr;
    logic                imem_rsp_valid;
    logic [ILEN-1:0]     imem_rsp_data;

    // Core side
    logic                inst_valid;
    logic                inst_ready;
    logic [ILEN-1:0]     inst;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic [FUNCT7_W-1:0] funct7;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     pc_plus4;
    logic                redirect;
    logic [XLEN-1:0]     redirect_target;
    logic                fetch_fault;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst, opcode, funct3, funct7, pc, pc_plus4,
        output fetch_fault,
        input  inst_ready, redirect, redirect_target
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst, opcode, funct3, funct7, pc, pc_plus4,
        input  fetch_fault,
        output inst_ready, redirect, redirect_target
    );

endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage: holds the PC, fetches one word
// at a time and hands a registered instruction to the monocycle control unit.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [ILEN-1:0] NOP_INST = RV_NOP_INST
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master fetch_if
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [ILEN-1:0] inst_q;
    logic            req_valid_q;
    logic            inst_valid_q;
    logic            fault_q;

    logic            accept_c;
    logic [XLEN-1:0] pc_plus4_c;
    logic [XLEN-1:0] next_pc_d;

    assign accept_c   = inst_valid_q & fetch_if.inst_ready;
    assign pc_plus4_c = pc_q + XLEN'(4);

    // Redirect target is taken as-is; jalr bit-0 masking happens upstream.
    always_comb begin
        next_pc_d = pc_plus4_c;
        if (fetch_if.redirect) begin
            next_pc_d = fetch_if.redirect_target;
        end
    end

    // Fetch FSM; status outputs are registered alongside the state transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q     <= ST_REQ;
                    req_valid_q <= 1'b1;
                end

                ST_REQ: begin
                    if (fetch_if.imem_req_ready) begin
                        state_q     <= ST_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end

                ST_WAIT: begin
                    if (fetch_if.imem_rsp_valid) begin
                        state_q      <= ST_HOLD;
                        inst_q       <= fetch_if.imem_rsp_data;
                        inst_valid_q <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (accept_c) begin
                        inst_valid_q <= 1'b0;
                        inst_q       <= NOP_INST;
                        if (is_word_aligned(next_pc_d)) begin
                            state_q     <= ST_REQ;
                            pc_q        <= next_pc_d;
                            req_valid_q <= 1'b1;
                        end else begin
                            // PC keeps the faulting instruction's address.
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end
                    end
                end

                ST_FAULT: begin
                    req_valid_q  <= 1'b0;
                    inst_valid_q <= 1'b0;
                    inst_q       <= NOP_INST;
                end

                default: begin
                    state_q      <= ST_FAULT;
                    req_valid_q  <= 1'b0;
                    inst_valid_q <= 1'b0;
                    inst_q       <= NOP_INST;
                    fault_q      <= 1'b1;
                end
            endcase
        end
    end

    assign fetch_if.imem_req_valid = req_valid_q;
    assign fetch_if.imem_addr      = pc_q;

    assign fetch_if.inst_valid  = inst_valid_q;
    assign fetch_if.inst        = inst_q;
    assign fetch_if.opcode      = inst_q[OPCODE_MSB:OPCODE_LSB];
    assign fetch_if.funct3      = inst_q[FUNCT3_MSB:FUNCT3_LSB];
    assign fetch_if.funct7      = inst_q[FUNCT7_MSB:FUNCT7_LSB];
    assign fetch_if.pc          = pc_q;
    assign fetch_if.pc_plus4    = pc_plus4_c;
    assign fetch_if.fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small memory responder driven inline,
// expected addresses/instructions queued on stimulus and checked on output.
module tb_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_inst_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_total;
    int   n_pass;
    int   rise_cyc;

    logic [31:0] addr_q[$];
    exp_inst_t   inst_q[$];

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(32'h0000_0013)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .fetch_if(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cyc);
        $fatal(1);
    end

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return 32'h0050_0093 ^ (a << 5);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one edge and settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, answer it with zero-wait memory, check the result.
    task automatic fetch(input logic [31:0] exp_pc);
        int        waited;
        logic [31:0] data;
        exp_inst_t e;
        addr_q.push_back(exp_pc);
        waited = 0;
        while (bus.imem_req_valid !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        check("req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("req_addr", bus.imem_addr, addr_q.pop_front());
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        check("wait_no_req", 32'(bus.imem_req_valid), 32'd0);
        data = mem_of(exp_pc);
        inst_q.push_back('{pc: exp_pc, inst: data});
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = JUNK;
        e = inst_q.pop_front();
        check("inst_valid", 32'(bus.inst_valid), 32'd1);
        check("inst", bus.inst, e.inst);
        check("pc", bus.pc, e.pc);
    endtask

    task automatic accept(input logic redir, input logic [31:0] target);
        bus.inst_ready      = 1'b1;
        bus.redirect        = redir;
        bus.redirect_target = target;
        tick();
        bus.inst_ready      = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = JUNK;
        check("acc_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("acc_inst_nop", bus.inst, NOP);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        rise_cyc = cyc;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = JUNK;
        bus.inst_ready      = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = JUNK;
        tick();

        // Reset state
        do_reset();
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_fault", 32'(bus.fetch_fault), 32'd0);
        check("rst_inst", bus.inst, NOP);
        check("rst_pc", bus.pc, 32'h0);

        // First fetch: request one edge after release, instruction three edges after
        tick();
        check("first_req_cycle", 32'(cyc - rise_cyc), 32'd1);
        fetch(32'h0);
        check("first_inst_cycle", 32'(cyc - rise_cyc), 32'd3);
        check("first_opcode", 32'(bus.opcode), 32'h13);
        check("first_funct3", 32'(bus.funct3), 32'h0);
        check("first_funct7", 32'(bus.funct7), 32'h0);
        check("first_pc_plus4", bus.pc_plus4, 32'h4);

        // Sequential fetches
        accept(1'b0, JUNK);
        fetch(32'h4);
        accept(1'b0, JUNK);
        fetch(32'h8);

        // Core stall in HOLD
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_inst", bus.inst, mem_of(32'h8));
            check("stall_pc", bus.pc, 32'h8);
            check("stall_no_req", 32'(bus.imem_req_valid), 32'd0);
            check("stall_valid", 32'(bus.inst_valid), 32'd1);
        end
        accept(1'b0, JUNK);
        fetch(32'hC);

        // Memory back-pressure with a stray response while requesting
        accept(1'b0, JUNK);
        for (int i = 0; i < 4; i++) begin
            bus.imem_rsp_valid = (i == 1);
            bus.imem_rsp_data  = JUNK;
            tick();
            check("bp_addr", bus.imem_addr, 32'h10);
            check("bp_req", 32'(bus.imem_req_valid), 32'd1);
            check("bp_inst_valid", 32'(bus.inst_valid), 32'd0);
        end
        bus.imem_rsp_valid = 1'b0;
        fetch(32'h10);

        // Redirects, including PC wrap
        accept(1'b1, 32'h100);
        fetch(32'h100);
        accept(1'b1, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC);
        check("wrap_pc_plus4", bus.pc_plus4, 32'h0);
        accept(1'b0, JUNK);
        fetch(32'h0);
        check("wrap_no_fault", 32'(bus.fetch_fault), 32'd0);

        // Misaligned redirect faults and stays quiet
        accept(1'b1, 32'h102);
        for (int i = 0; i < 5; i++) begin
            check("fault_flag", 32'(bus.fetch_fault), 32'd1);
            check("fault_no_req", 32'(bus.imem_req_valid), 32'd0);
            check("fault_pc", bus.pc, 32'h0);
            tick();
        end

        // Reset during WAIT drops the late response
        do_reset();
        check("rst2_fault", 32'(bus.fetch_fault), 32'd0);
        tick();
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        check("rst2_in_wait", 32'(bus.imem_req_valid), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = JUNK;
        tick();
        bus.imem_rsp_valid = 1'b0;
        check("drop_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("drop_inst", bus.inst, NOP);
        fetch(32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the monocycle control_unit.
- Holds the PC and issues one request at a time to instruction memory over a valid/ready request channel and a valid response channel.
- Registers the returned instruction and presents it with opcode/funct3/funct7 slices to the control unit and the register file.
- Selects the next PC (sequential or redirect target) when the core accepts the instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned
NOP_INST, 32'h0000_0013, instruction presented when none is valid (addi x0,x0,0)

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_addr  out  32  request address (= pc)
imem_rsp_valid  in  1  response data valid
imem_rsp_data  in  32  fetched instruction
inst_valid  out  1  inst holds a fetched, unconsumed instruction
inst_ready  in  1  core consumes inst this cycle (low = stall)
inst  out  32  registered instruction
opcode  out  7  inst[6:0]
funct3  out  3  inst[14:12]
funct7  out  7  inst[31:25]
pc  out  32  address of inst
pc_plus4  out  32  pc + 4, for jal/jalr link
redirect  in  1  take redirect_target instead of pc+4; sampled only on accept
redirect_target  in  32  branch/jump target from ALU
fetch_fault  out  1  sticky misaligned-target fault

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=BOOT, pc=RESET_PC, inst=NOP_INST.
  - inst_valid=0, imem_req_valid=0, fetch_fault=0.
  - Any outstanding response is discarded.
- States: BOOT, REQ, WAIT, HOLD, FAULT.
- BOOT: req_valid=0. Goes to REQ on the next edge, so the first request is the 1st cycle after rst_n rises.
- REQ:
  - imem_req_valid=1, imem_addr=pc.
  - If imem_req_ready goes to WAIT; otherwise stays, with addr held stable.
- WAIT:
  - req_valid=0.
  - If imem_rsp_valid: inst<=imem_rsp_data, inst_valid<=1, go to HOLD.
  - imem_rsp_valid in any state other than WAIT is ignored.
- HOLD:
  - inst_valid=1; inst, pc and slices held stable while inst_ready=0 (stall of any length).
  - Accept = inst_valid & inst_ready. On accept, inst_valid<=0 and next_pc = redirect ? redirect_target : pc+4.
  - If next_pc[1:0]!=0: fetch_fault<=1, pc unchanged, go to FAULT.
  - Otherwise pc<=next_pc and go to REQ.
- FAULT: req_valid=0, inst_valid=0. Exits only via reset.
- Outputs:
  - inst_valid, imem_req_valid and fetch_fault are registered, decoded from state.
  - opcode/funct3/funct7/pc_plus4 are combinational from the registered inst and pc.
  - When inst_valid=0, inst=NOP_INST so the control unit sees a harmless opcode.
- Arithmetic: pc+4 is modulo 2^32 (pc=32'hFFFF_FFFC gives 32'h0000_0000, no fault). redirect_target is used unmodified (no bit-0 clearing; jalr masking is upstream's job).
- Latency with zero-wait memory (ready=1, response 1 cycle after acceptance):
  - REQ -> WAIT -> HOLD, so inst_valid rises 3 edges after rst_n rises.
  - Steady state: 1 instruction per 3 cycles with inst_ready=1.
- Exactly one outstanding request; no request is issued while in WAIT or HOLD.
- redirect and redirect_target are don't-care when there is no accept.

Decomposition:
- Shared package rv_pkg: fetch state enum, NOP_INST, opcode field ranges, and XLEN=32.
- The opcode localparams used by control_unit move into the same package.
- No sub-module; next-PC logic is small enough to stay inline.

Test Plan:
- Reset release, RESET_PC=0, memory returns 32'h00500093 -> req at cycle 1 with addr 0; inst_valid at cycle 3; opcode 7'b0010011; pc_plus4=4.
- Three sequential accepts with inst_ready=1 -> imem_addr sequence 0, 4, 8; pc matches each inst.
- inst_ready=0 for 5 cycles in HOLD -> inst/pc stable; no new request; after release, next addr = pc+4.
- Accept with redirect=1, target=32'h100 -> next imem_addr=32'h100. Repeat with target=32'h102 -> fetch_fault=1, no further requests until reset.
- imem_req_ready low for 4 cycles -> imem_addr stable. A stray imem_rsp_valid in REQ is ignored, and inst_valid stays 0.
- rst_n low during WAIT, then the response arrives -> response dropped; after release, the first fetch is again RESET_PC. Also pc=32'hFFFF_FFFC accept -> next addr 0.
